trap_controller: RTL and testbench

Machine-mode trap sequencer sitting directly upstream of the CSR unit. Watches the execute stage for synchronous exceptions, an external interrupt and `mret`, then runs a fixed flush/save/redirect sequence. It drives the CSR unit's write strobe and PC-to-save, and redirects fetch to the trap vector or back to the saved return address.

---
 rtl/trap_pkg.sv | 17 +
 rtl/trap_cause_encoder.sv | 26 ++
 rtl/trap_controller.sv | 162 ++++++++++++++++
 tb/tb_trap_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and cause codes for the machine-mode trap sequencer.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_SAVE     = 2'd2,
    ST_REDIRECT = 2'd3
  } trap_state_e;

  localparam logic [31:0] CAUSE_MISALIGNED = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK     = 32'd3;
  localparam logic [31:0] CAUSE_ECALL      = 32'd11;
  localparam logic [31:0] CAUSE_MEXT_IRQ   = 32'h8000_000B;

endpackage

// File: rtl/trap_cause_encoder.sv
// Priority encoder: exception flags beat the interrupt, lowest cause code wins.
module trap_cause_encoder
  import trap_pkg::*;
(
  input  logic        exc_misaligned_i,
  input  logic        exc_illegal_i,
  input  logic        exc_ebreak_i,
  input  logic        exc_ecall_i,
  input  logic        irq_accept_i,
  output logic        valid_o,
  output logic [31:0] cause_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the if-chain leaves it unassigned (no latch).
    valid_o = 1'b1;
    cause_o = '0;
    if (exc_misaligned_i)  cause_o = CAUSE_MISALIGNED;
    else if (exc_illegal_i) cause_o = CAUSE_ILLEGAL;
    else if (exc_ebreak_i)  cause_o = CAUSE_EBREAK;
    else if (exc_ecall_i)   cause_o = CAUSE_ECALL;
    else if (irq_accept_i)  cause_o = CAUSE_MEXT_IRQ;
    else                    valid_o = 1'b0;
  end

endmodule

// File: rtl/trap_controller.sv
// Trap flush/save/redirect sequencer feeding the CSR unit.
// Define TRAP_INTERRUPT_EN to add external-interrupt acceptance and mie/mpie state.
module trap_controller
  import trap_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clock,
  input  logic        resetActiveHigh,
  input  logic        instrValid,
  input  logic [31:0] instrPc,
  input  logic        excMisaligned,
  input  logic        excIllegal,
  input  logic        excEbreak,
  input  logic        excEcall,
  input  logic        mretRequest,
  input  logic        interruptRequest,
  input  logic [31:0] mepcValue,
  output logic        csrWriteEnable,
  output logic [31:0] pcToSave,
  output logic [31:0] mcauseValue,
  output logic        flushPipeline,
  output logic        stallFetch,
  output logic        redirectValid,
  output logic [31:0] redirectTarget,
  output logic        trapBusy
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);

  trap_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      cause_q, cause_d;
  logic [31:0]      mcause_q, mcause_d;
  logic             redir_valid_q, redir_valid_d;
  logic [31:0]      redir_target_q, redir_target_d;

  logic        is_idle;
  logic        irq_accept;
  logic        enc_valid;
  logic [31:0] enc_cause;
  logic        mret_take;

  assign is_idle = (state_q == ST_IDLE);

`ifdef TRAP_INTERRUPT_EN
  logic mie_q, mie_d;
  logic mpie_q, mpie_d;
  assign irq_accept = is_idle && instrValid && interruptRequest && mie_q &&
                      !(excMisaligned || excIllegal || excEbreak || excEcall);
`else
  logic unused_irq;
  assign unused_irq = interruptRequest;
  assign irq_accept = 1'b0;
`endif

  trap_cause_encoder u_cause_enc (
    .exc_misaligned_i (excMisaligned && instrValid),
    .exc_illegal_i    (excIllegal && instrValid),
    .exc_ebreak_i     (excEbreak && instrValid),
    .exc_ecall_i      (excEcall && instrValid),
    .irq_accept_i     (irq_accept),
    .valid_o          (enc_valid),
    .cause_o          (enc_cause)
  );

  assign mret_take = instrValid && mretRequest && !enc_valid;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    mcause_d       = mcause_q;
    redir_valid_d  = 1'b0;
    redir_target_d = '0;
`ifdef TRAP_INTERRUPT_EN
    mie_d          = mie_q;
    mpie_d         = mpie_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          state_d = ST_FLUSH;
          cnt_d   = DRAIN_LOAD;
          pc_d    = instrPc;
          cause_d = enc_cause;
        end else if (mret_take) begin
          redir_valid_d  = 1'b1;
          redir_target_d = mepcValue;
`ifdef TRAP_INTERRUPT_EN
          mie_d          = mpie_q;
          mpie_d         = 1'b1;
`endif
        end
      end
      ST_FLUSH: begin
        // mcause is loaded on entry to SAVE so it is already valid during the write strobe.
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_SAVE;
          mcause_d = cause_q;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end
      ST_SAVE: begin
        state_d        = ST_REDIRECT;
        redir_valid_d  = 1'b1;
        redir_target_d = TRAP_VECTOR;
`ifdef TRAP_INTERRUPT_EN
        mpie_d         = mie_q;
        mie_d          = 1'b0;
`endif
      end
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (resetActiveHigh) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      pc_q           <= '0;
      cause_q        <= '0;
      mcause_q       <= '0;
      redir_valid_q  <= 1'b0;
      redir_target_q <= '0;
`ifdef TRAP_INTERRUPT_EN
      mie_q          <= 1'b1;
      mpie_q         <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pc_q           <= pc_d;
      cause_q        <= cause_d;
      mcause_q       <= mcause_d;
      redir_valid_q  <= redir_valid_d;
      redir_target_q <= redir_target_d;
`ifdef TRAP_INTERRUPT_EN
      mie_q          <= mie_d;
      mpie_q         <= mpie_d;
`endif
    end
  end

  assign csrWriteEnable = (state_q == ST_SAVE);
  assign pcToSave       = (state_q == ST_SAVE) ? pc_q : '0;
  assign mcauseValue    = mcause_q;
  assign flushPipeline  = (state_q == ST_FLUSH);
  assign stallFetch     = (state_q == ST_FLUSH) || (state_q == ST_SAVE);
  assign redirectValid  = redir_valid_q;
  assign redirectTarget = redir_target_q;
  assign trapBusy       = !is_idle;

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: two instances (drain 2 and drain 1) share one stimulus stream.
module tb_trap_controller;

  localparam logic [31:0] VEC = 32'h0000_0100;
  localparam int D0 = 2;
  localparam int D1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid;
  logic [31:0] pc;
  logic        mis, ill, ebk, ecl;
  logic        mret_req;
  logic        irq;
  logic [31:0] mepc;

  logic        csr_we   [2];
  logic [31:0] pc_save  [2];
  logic [31:0] mcause   [2];
  logic        flush    [2];
  logic        stall    [2];
  logic        rvalid   [2];
  logic [31:0] rtarget  [2];
  logic        busy     [2];

  trap_controller #(.TRAP_VECTOR(VEC), .DRAIN_CYCLES(D0)) u_dut0 (
    .clock(clk), .resetActiveHigh(rst), .instrValid(valid), .instrPc(pc),
    .excMisaligned(mis), .excIllegal(ill), .excEbreak(ebk), .excEcall(ecl),
    .mretRequest(mret_req), .interruptRequest(irq), .mepcValue(mepc),
    .csrWriteEnable(csr_we[0]), .pcToSave(pc_save[0]), .mcauseValue(mcause[0]),
    .flushPipeline(flush[0]), .stallFetch(stall[0]), .redirectValid(rvalid[0]),
    .redirectTarget(rtarget[0]), .trapBusy(busy[0])
  );

  trap_controller #(.TRAP_VECTOR(VEC), .DRAIN_CYCLES(D1)) u_dut1 (
    .clock(clk), .resetActiveHigh(rst), .instrValid(valid), .instrPc(pc),
    .excMisaligned(mis), .excIllegal(ill), .excEbreak(ebk), .excEcall(ecl),
    .mretRequest(mret_req), .interruptRequest(irq), .mepcValue(mepc),
    .csrWriteEnable(csr_we[1]), .pcToSave(pc_save[1]), .mcauseValue(mcause[1]),
    .flushPipeline(flush[1]), .stallFetch(stall[1]), .redirectValid(rvalid[1]),
    .redirectTarget(rtarget[1]), .trapBusy(busy[1])
  );

  // Expected CSR writes (a=pc, b=cause) and redirects (a=target), tagged by instance and output window.
  typedef struct {
    int          dut;
    int          win;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t csr_q[$];
  exp_t rd_q[$];

  int drain   [2] = '{D0, D1};
  int idle_at [2] = '{0, 0};
  int trap_n  [2] = '{-1000, -1000};
  bit mie     [2] = '{1'b1, 1'b1};
  bit mpie    [2] = '{1'b1, 1'b1};
  int last_rst = -1;
  int cyc      = 0;
  int n_checks = 0;
  int n_err    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @window %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] exc_cause(input logic m, input logic i, input logic b);
    if (m) return 32'd0;
    if (i) return 32'd2;
    if (b) return 32'd3;
    return 32'd11;
  endfunction

  task automatic purge(input int d);
    for (int i = csr_q.size() - 1; i >= 0; i--) if (csr_q[i].dut == d) csr_q.delete(i);
    for (int i = rd_q.size() - 1; i >= 0; i--) if (rd_q[i].dut == d) rd_q.delete(i);
  endtask

  // Reference model: predicts, per instance, what the upcoming edge e does.
  task automatic model_edge(input int e);
    bit any_exc, irq_acc;
    any_exc = valid && (mis || ill || ebk || ecl);
    if (rst) last_rst = e;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        idle_at[d] = e + 1;
        trap_n[d]  = -1000;
        mie[d]     = 1'b1;
        mpie[d]    = 1'b1;
        purge(d);
      end else if (e >= idle_at[d]) begin
        irq_acc = 1'b0;
`ifdef TRAP_INTERRUPT_EN
        irq_acc = valid && irq && mie[d] && !any_exc;
`endif
        if (any_exc || irq_acc) begin
          csr_q.push_back('{d, e + drain[d], pc,
                            any_exc ? exc_cause(mis, ill, ebk) : 32'h8000_000B});
          rd_q.push_back('{d, e + drain[d] + 1, VEC, 32'd0});
          trap_n[d]  = e;
          idle_at[d] = e + drain[d] + 3;
          mpie[d]    = mie[d];
          mie[d]     = 1'b0;
        end else if (valid && mret_req) begin
          rd_q.push_back('{d, e, mepc, 32'd0});
          mie[d]  = mpie[d];
          mpie[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic monitor_dut(input int d, input int w);
    int ci, ri, t, dd;
    string s;
    s  = $sformatf("dut%0d", d);
    ci = -1;
    ri = -1;
    for (int i = 0; i < csr_q.size(); i++) if (csr_q[i].dut == d) begin ci = i; break; end
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i].dut == d) begin ri = i; break; end
    if (ci >= 0 && csr_q[ci].win == w) begin
      check({s, " csr_we"}, 32'(csr_we[d]), 32'd1);
      check({s, " pc_save"}, pc_save[d], csr_q[ci].a);
      check({s, " mcause"}, mcause[d], csr_q[ci].b);
      csr_q.delete(ci);
    end else begin
      check({s, " csr_we_idle"}, 32'(csr_we[d]), 32'd0);
    end
    if (ri >= 0 && rd_q[ri].win == w) begin
      check({s, " redirect_valid"}, 32'(rvalid[d]), 32'd1);
      check({s, " redirect_target"}, rtarget[d], rd_q[ri].a);
      rd_q.delete(ri);
    end else begin
      check({s, " redirect_idle"}, 32'(rvalid[d]), 32'd0);
    end
    t  = trap_n[d];
    dd = drain[d];
    check({s, " flush"}, 32'(flush[d]), 32'(w >= t && w <= t + dd - 1));
    check({s, " stall"}, 32'(stall[d]), 32'(w >= t && w <= t + dd));
    check({s, " busy"},  32'(busy[d]),  32'(w >= t && w <= t + dd + 1));
    if (w == last_rst) begin
      check({s, " rst_pc_save"}, pc_save[d], 32'd0);
      check({s, " rst_mcause"}, mcause[d], 32'd0);
      check({s, " rst_target"}, rtarget[d], 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      monitor_dut(0, cyc);
      monitor_dut(1, cyc);
    end
  end

  task automatic apply(input logic r, input logic v, input logic [31:0] p,
                       input logic [3:0] exc, input logic m, input logic i,
                       input logic [31:0] mp);
    @(negedge clk);
    #1;
    rst      = r;
    valid    = v;
    pc       = p;
    {mis, ill, ebk, ecl} = exc;
    mret_req = m;
    irq      = i;
    mepc     = mp;
    model_edge(cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0);
  endtask

  logic irq_lvl;

  initial begin
    rst = 1'b1; valid = 1'b0; pc = '0; mis = 1'b0; ill = 1'b0; ebk = 1'b0; ecl = 1'b0;
    mret_req = 1'b0; irq = 1'b0; mepc = '0;
    model_edge(1);
    for (int k = 0; k < 2; k++) apply(1'b1, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0);
    idle(3);

    // Illegal instruction at 0x40.
    apply(1'b0, 1'b1, 32'h40, 4'b0100, 1'b0, 1'b0, 32'h0);
    idle(6);

    // Ecall with misaligned, then a second exception while flushing.
    apply(1'b0, 1'b1, 32'h44, 4'b1001, 1'b0, 1'b0, 32'h0);
    apply(1'b0, 1'b1, 32'h48, 4'b0100, 1'b0, 1'b0, 32'h0);
    idle(6);

    // Ebreak alone, plain mret back to a chosen return address.
    apply(1'b0, 1'b1, 32'h50, 4'b0010, 1'b0, 1'b0, 32'h0);
    idle(6);
    apply(1'b0, 1'b1, 32'h60, 4'b0000, 1'b1, 1'b0, 32'h1234);
    idle(2);

    // Interrupt at 0x80 held high through the handler, then mret, then taken again.
    apply(1'b0, 1'b1, 32'h80, 4'b0000, 1'b0, 1'b1, 32'h0);
    for (int k = 0; k < 8; k++) apply(1'b0, 1'b1, 32'h104 + 32'(4 * k), 4'b0000, 1'b0, 1'b1, 32'h0);
    apply(1'b0, 1'b1, 32'h130, 4'b0000, 1'b1, 1'b1, 32'h80);
    apply(1'b0, 1'b1, 32'h80, 4'b0000, 1'b0, 1'b1, 32'h0);
    idle(8);
    apply(1'b0, 1'b1, 32'h140, 4'b0000, 1'b1, 1'b0, 32'h84);
    idle(2);

    // Reset pulsed during FLUSH.
    apply(1'b0, 1'b1, 32'h200, 4'b0001, 1'b0, 1'b0, 32'h0);
    apply(1'b1, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0);
    idle(6);

    // Randomized traffic.
    irq_lvl = 1'b0;
    for (int k = 0; k < 2500; k++) begin
      logic        r, v, m;
      logic [3:0]  ex;
      logic [31:0] p, mp;
      if ($urandom_range(0, 9) == 0) irq_lvl = ~irq_lvl;
      r  = ($urandom_range(0, 149) == 0);
      v  = ($urandom_range(0, 9) < 7);
      ex = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
      m  = ($urandom_range(0, 11) == 0);
      p  = $urandom() & 32'hFFFF_FFFC;
      mp = $urandom() & 32'hFFFF_FFFC;
      apply(r, v, p, ex, m, irq_lvl, mp);
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
